lsu_req_sink: RTL and testbench

- Slave-side endpoint of the LSU request channel; sits between the dispatch/issue stage and the data-cache request port.
- Accepts one LSU request per handshake and computes per-thread effective addresses as base_addr + offset.
- Serializes active threads into single-word memory requests, one thread per cycle.
- Tracks outstanding loads and resolves fences once all outstanding loads have drained.

---
 rtl/lsu_req_sink.sv | 215 +++++++++++++++++++++
 tb/tb_lsu_req_sink.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_req_sink.sv
// LSU request sink: accepts one LSU request, serializes active threads into word requests,
// tracks outstanding loads and resolves fences. Optional perf counters: LSU_REQ_SINK_PERF_EN.
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef INST_LSU_BITS
`define INST_LSU_BITS 4
`endif

module lsu_req_sink #(
    parameter int MAX_PENDING = 16,
    parameter int PERF_CTR_W  = 32,
    localparam int NT_BITS = (`NUM_THREADS > 1) ? $clog2(`NUM_THREADS) : 1,
    localparam int PC_W    = $clog2(MAX_PENDING) + 1,
    localparam int TAG_W   = `UUID_BITS + `NW_BITS + NT_BITS + `NR_BITS + 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [`UUID_BITS-1:0]         req_uuid,
    input  logic [`NW_BITS-1:0]           req_wid,
    input  logic [`NUM_THREADS-1:0]       req_tmask,
    input  logic [31:0]                   req_PC,
    input  logic [`INST_LSU_BITS-1:0]     req_op_type,
    input  logic                          req_is_fence,
    input  logic [`NUM_THREADS*32-1:0]    req_store_data,
    input  logic [`NUM_THREADS*32-1:0]    req_base_addr,
    input  logic [31:0]                   req_offset,
    input  logic [`NR_BITS-1:0]           req_rd,
    input  logic                          req_wb,
    input  logic                          req_is_prefetch,
    output logic                          req_ready,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_rw,
    output logic                          mem_req_prefetch,
    output logic [29:0]                   mem_req_addr,
    output logic [3:0]                    mem_req_byteen,
    output logic [31:0]                   mem_req_data,
    output logic [TAG_W-1:0]              mem_req_tag,
    output logic                          mem_req_last,
    input  logic                          mem_rsp_done,
    output logic                          fence_done_valid,
    output logic [`NW_BITS-1:0]           fence_done_wid,
    output logic [PC_W-1:0]               pending_cnt,
    output logic                          misalign_err,
    output logic                          underflow_err,
    output logic [1:0]                    dbg_state
`ifdef LSU_REQ_SINK_PERF_EN
    ,
    output logic [PERF_CTR_W-1:0]         perf_loads,
    output logic [PERF_CTR_W-1:0]         perf_stores,
    output logic [PERF_CTR_W-1:0]         perf_stall_cycles
`endif
);
    // Handshakes: a transfer happens on a clock edge where valid && ready; the
    // source keeps valid and payload stable until then (req_* and mem_req_*).
    typedef enum logic [1:0] { IDLE = 2'd0, ISSUE = 2'd1, FENCE_WAIT = 2'd2 } state_t;

    state_t                           state_q, state_d;
    logic [`UUID_BITS-1:0]            uuid_q;
    logic [`NW_BITS-1:0]              wid_q;
    logic [`NR_BITS-1:0]              rd_q;
    logic                             wb_q, pf_q;
    logic [3:0]                       op_q;
    logic [`NUM_THREADS-1:0]          remaining_q, remaining_clr;
    logic [`NUM_THREADS-1:0][31:0]    store_data_q, ea_q, ea_in;
    logic [PC_W-1:0]                  pending_q;
    logic                             misalign_q, underflow_q;

    logic [NT_BITS-1:0]               tid;
    logic [31:0]                      ea_cur;
    logic                             in_issue, misaligned, load_hold, fire, accept, pend_inc;
    logic                             unused_sig;

    always_comb begin
        for (int i = 0; i < `NUM_THREADS; i++)
            ea_in[i] = req_base_addr[i*32 +: 32] + req_offset;
    end

    always_comb begin
        tid = '0;
        for (int i = `NUM_THREADS - 1; i >= 0; i--)
            if (remaining_q[i]) tid = NT_BITS'(i);
    end

    assign accept        = req_valid && (state_q == IDLE);
    assign in_issue      = (state_q == ISSUE);
    assign ea_cur        = ea_q[tid];
    assign misaligned    = ((op_q[1:0] == 2'd1) && ea_cur[0]) ||
                           ((op_q[1:0] == 2'd2) && (ea_cur[1:0] != 2'b00));
    // Only demand loads consume a pending slot, so only they wait for one.
    assign load_hold     = !op_q[3] && !pf_q && (pending_q == PC_W'(MAX_PENDING));
    assign remaining_clr = remaining_q & ~(`NUM_THREADS'(1) << tid);
    assign fire          = mem_req_valid && mem_req_ready;
    assign pend_inc      = fire && !op_q[3] && !pf_q;

    assign req_ready        = (state_q == IDLE);
    assign mem_req_valid    = in_issue && !misaligned && !load_hold;
    assign mem_req_rw       = in_issue && op_q[3];
    assign mem_req_prefetch = in_issue && pf_q;
    assign mem_req_addr     = in_issue ? ea_cur[31:2] : '0;
    assign mem_req_data     = in_issue ? (store_data_q[tid] << {ea_cur[1:0], 3'b000}) : '0;
    assign mem_req_tag      = in_issue ? {uuid_q, wid_q, tid, rd_q, wb_q & ~op_q[3],
                                          op_q[2:0], ea_cur[1:0]} : '0;
    assign mem_req_last     = in_issue && (remaining_clr == '0);
    assign fence_done_wid   = fence_done_valid ? wid_q : '0;
    assign pending_cnt      = pending_q;
    assign misalign_err     = misalign_q;
    assign underflow_err    = underflow_q;
    assign dbg_state        = state_q;

    always_comb begin
        mem_req_byteen = 4'h0;
        if (in_issue) begin
            case (op_q[1:0])
                2'd0:    mem_req_byteen = 4'b0001 << ea_cur[1:0];
                2'd1:    mem_req_byteen = 4'b0011 << ea_cur[1:0];
                default: mem_req_byteen = 4'hF;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        fence_done_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_is_fence)        state_d = FENCE_WAIT;
                    else if (req_tmask != 0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if ((fire || misaligned) && (remaining_clr == '0)) state_d = IDLE;
            end
            FENCE_WAIT: begin
                if (pending_q == '0) begin
                    fence_done_valid = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            uuid_q       <= '0;
            wid_q        <= '0;
            rd_q         <= '0;
            wb_q         <= 1'b0;
            pf_q         <= 1'b0;
            op_q         <= '0;
            remaining_q  <= '0;
            store_data_q <= '0;
            ea_q         <= '0;
            pending_q    <= '0;
            misalign_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                uuid_q       <= req_uuid;
                wid_q        <= req_wid;
                rd_q         <= req_rd;
                wb_q         <= req_wb;
                pf_q         <= req_is_prefetch;
                op_q         <= req_op_type[3:0];
                remaining_q  <= req_is_fence ? '0 : req_tmask;
                store_data_q <= req_store_data;
                ea_q         <= ea_in;
            end else if (in_issue && (fire || misaligned)) begin
                remaining_q <= remaining_clr;
            end
            if (in_issue && misaligned) misalign_q <= 1'b1;
            // Increment and retire in the same cycle cancel out.
            if (pend_inc && !mem_rsp_done) begin
                pending_q <= pending_q + 1'b1;
            end else if (!pend_inc && mem_rsp_done) begin
                if (pending_q == '0) underflow_q <= 1'b1;
                else                 pending_q   <= pending_q - 1'b1;
            end
        end
    end

`ifdef LSU_REQ_SINK_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_loads        <= '0;
            perf_stores       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (fire && !op_q[3]) perf_loads  <= perf_loads + 1'b1;
            if (fire && op_q[3])  perf_stores <= perf_stores + 1'b1;
            if (in_issue && !fire && (mem_req_valid || (load_hold && !misaligned)))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
    assign unused_sig = ^req_PC;
`else
    assign unused_sig = ^{req_PC, 32'(PERF_CTR_W)};
`endif

endmodule

// File: tb/tb_lsu_req_sink.sv
// Scoreboard bench for lsu_req_sink: directed requests push expected memory
// requests / fence completions; negedge monitors pop and compare.
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef INST_LSU_BITS
`define INST_LSU_BITS 4
`endif

module tb_lsu_req_sink;
  localparam int MAXP  = 4;
  localparam int PC_W  = $clog2(MAXP) + 1;
  localparam int NT    = `NUM_THREADS;
  localparam int TAG_W = `UUID_BITS + `NW_BITS + 2 + `NR_BITS + 6;
  localparam int EXP_W = 1 + 1 + 30 + 4 + 32 + 1 + TAG_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                       req_valid = 1'b0;
  logic [`UUID_BITS-1:0]      req_uuid = '0;
  logic [`NW_BITS-1:0]        req_wid = '0;
  logic [NT-1:0]              req_tmask = '0;
  logic [31:0]                req_PC = '0;
  logic [`INST_LSU_BITS-1:0]  req_op_type = '0;
  logic                       req_is_fence = 1'b0;
  logic [NT*32-1:0]           req_store_data = '0;
  logic [NT*32-1:0]           req_base_addr = '0;
  logic [31:0]                req_offset = '0;
  logic [`NR_BITS-1:0]        req_rd = '0;
  logic                       req_wb = 1'b0;
  logic                       req_is_prefetch = 1'b0;
  logic                       req_ready;
  logic                       mem_req_valid;
  logic                       mem_req_ready = 1'b1;
  logic                       mem_req_rw, mem_req_prefetch, mem_req_last;
  logic [29:0]                mem_req_addr;
  logic [3:0]                 mem_req_byteen;
  logic [31:0]                mem_req_data;
  logic [TAG_W-1:0]           mem_req_tag;
  logic                       mem_rsp_done = 1'b0;
  logic                       fence_done_valid;
  logic [`NW_BITS-1:0]        fence_done_wid;
  logic [PC_W-1:0]            pending_cnt;
  logic                       misalign_err, underflow_err;
  logic [1:0]                 dbg_state;
`ifdef LSU_REQ_SINK_PERF_EN
  logic [31:0]                perf_loads, perf_stores, perf_stall_cycles;
`endif

  lsu_req_sink #(.MAX_PENDING(MAXP), .PERF_CTR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_uuid(req_uuid),
    .req_wid(req_wid), .req_tmask(req_tmask), .req_PC(req_PC),
    .req_op_type(req_op_type), .req_is_fence(req_is_fence),
    .req_store_data(req_store_data), .req_base_addr(req_base_addr),
    .req_offset(req_offset), .req_rd(req_rd), .req_wb(req_wb),
    .req_is_prefetch(req_is_prefetch), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_prefetch(mem_req_prefetch),
    .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_last(mem_req_last), .mem_rsp_done(mem_rsp_done),
    .fence_done_valid(fence_done_valid), .fence_done_wid(fence_done_wid),
    .pending_cnt(pending_cnt), .misalign_err(misalign_err),
    .underflow_err(underflow_err), .dbg_state(dbg_state)
`ifdef LSU_REQ_SINK_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // scoreboard
  logic [EXP_W-1:0]    exp_q[$];
  logic [`NW_BITS-1:0] fence_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TAG_W-1:0] tag_of(input logic [`UUID_BITS-1:0] uuid,
      input logic [`NW_BITS-1:0] wid, input logic [1:0] tid, input logic [`NR_BITS-1:0] rd,
      input logic wb, input logic [2:0] op, input logic [1:0] off);
    return {uuid, wid, tid, rd, wb, op, off};
  endfunction

  function automatic logic [EXP_W-1:0] pack(input logic rw, input logic pf, input logic [29:0] addr,
      input logic [3:0] be, input logic [31:0] data, input logic last, input logic [TAG_W-1:0] tag);
    return {rw, pf, addr, be, data, last, tag};
  endfunction

  always @(negedge clk) begin
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_mem_req: got addr %0h with nothing expected", mem_req_addr);
      end else begin
        check("mem_req", pack(mem_req_rw, mem_req_prefetch, mem_req_addr, mem_req_byteen,
                              mem_req_data, mem_req_last, mem_req_tag), exp_q.pop_front());
      end
    end
    if (!reset && fence_done_valid) begin
      if (fence_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_fence_done: got wid %0d with nothing expected", fence_done_wid);
      end else begin
        check("fence_done_wid", fence_done_wid, fence_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic fence, input logic [`NW_BITS-1:0] wid,
      input logic [NT-1:0] tmask, input logic [3:0] op, input logic [NT*32-1:0] base,
      input logic [NT*32-1:0] sdata, input logic [31:0] offset,
      input logic [`UUID_BITS-1:0] uuid, input logic [`NR_BITS-1:0] rd, input logic wb);
    int n = 0;
    req_is_fence = fence; req_wid = wid; req_tmask = tmask; req_op_type = op;
    req_base_addr = base; req_store_data = sdata; req_offset = offset;
    req_uuid = uuid; req_rd = rd; req_wb = wb; req_is_prefetch = 1'b0;
    req_PC = 32'h8000_0000 + 32'(uuid);
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1");
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", req_ready, 1'b1);
  endtask

  task automatic rsp_pulse();
    mem_rsp_done = 1'b1;
    tick();
    mem_rsp_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_pending", pending_cnt, 0);
    check("rst_fence", fence_done_valid, 1'b0);
    check("rst_errs", {misalign_err, underflow_err}, 2'b00);
    reset = 1'b0;
    tick();

    // LW, tmask 1011, offset 4 -> words 0x41, 0x81, 0xC1
    exp_q.push_back(pack(0, 0, 30'h41, 4'hF, 32'h0, 0, tag_of(44'h1, 2'd1, 2'd0, 5'd3, 1, 3'b010, 2'b00)));
    exp_q.push_back(pack(0, 0, 30'h81, 4'hF, 32'h0, 0, tag_of(44'h1, 2'd1, 2'd1, 5'd3, 1, 3'b010, 2'b00)));
    exp_q.push_back(pack(0, 0, 30'hC1, 4'hF, 32'h0, 1, tag_of(44'h1, 2'd1, 2'd3, 5'd3, 1, 3'b010, 2'b00)));
    send_req(0, 2'd1, 4'b1011, 4'b0010, {32'h300, 32'hDEAD_BEEF, 32'h200, 32'h100},
             '0, 32'd4, 44'h1, 5'd3, 1'b1);
    wait_idle();
    check("lw_drained", exp_q.size(), 0);
    check("lw_pending", pending_cnt, 3);
    check("lw_no_misalign", misalign_err, 1'b0);

    // SB at 0x1003 -> word 0x400, lane 3
    exp_q.push_back(pack(1, 0, 30'h400, 4'b1000, 32'hAB00_0000, 1,
                         tag_of(44'h2, 2'd0, 2'd0, 5'd7, 0, 3'b000, 2'b11)));
    send_req(0, 2'd0, 4'b0001, 4'b1000, {96'h0, 32'h1003}, {96'h0, 32'h0000_00AB},
             32'd0, 44'h2, 5'd7, 1'b1);
    wait_idle();
    check("sb_drained", exp_q.size(), 0);
    check("sb_pending", pending_cnt, 3);

    // fence waits for two outstanding loads
    rsp_pulse();
    check("pend_after_rsp", pending_cnt, 2);
    send_req(1, 2'd2, 4'b1111, 4'b0000, '0, '0, 32'd0, 44'h3, 5'd0, 1'b0);
    check("fence_busy", req_ready, 1'b0);
    check("fence_state", dbg_state, 2'd2);
    rsp_pulse();
    check("fence_early", fence_done_valid, 1'b0);
    fence_q.push_back(2'd2);
    rsp_pulse();
    check("fence_pulse", fence_done_valid, 1'b1);
    tick();
    check("fence_once", fence_done_valid, 1'b0);
    check("fence_ready", req_ready, 1'b1);
    check("fence_q_empty", fence_q.size(), 0);

    // fence with nothing pending completes the cycle after accept
    fence_q.push_back(2'd1);
    send_req(1, 2'd1, 4'b0000, 4'b0000, '0, '0, 32'd0, 44'h4, 5'd0, 1'b0);
    check("fence0_pulse", fence_done_valid, 1'b1);
    tick();
    check("fence0_ready", req_ready, 1'b1);

    // tmask 0 retires in IDLE
    send_req(0, 2'd0, 4'b0000, 4'b0010, '0, '0, 32'd0, 44'h5, 5'd1, 1'b1);
    check("tmask0_ready", req_ready, 1'b1);
    check("tmask0_state", dbg_state, 2'd0);

    // fill MAX_PENDING, then a held load
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pack(0, 0, 30'h400 + 30'(i), 4'hF, 32'h0, (i == 3),
                           tag_of(44'h6, 2'd3, 2'(i), 5'd2, 1, 3'b010, 2'b00)));
    send_req(0, 2'd3, 4'b1111, 4'b0010, {32'd12, 32'd8, 32'd4, 32'd0}, '0,
             32'h1000, 44'h6, 5'd2, 1'b1);
    wait_idle();
    check("full_pending", pending_cnt, 4);
    exp_q.push_back(pack(0, 0, 30'h800, 4'hF, 32'h0, 1, tag_of(44'h7, 2'd0, 2'd0, 5'd4, 1, 3'b010, 2'b00)));
    send_req(0, 2'd0, 4'b0001, 4'b0010, {96'h0, 32'h2000}, '0, 32'd0, 44'h7, 5'd4, 1'b1);
    check("hold_valid0", mem_req_valid, 1'b0);
    tick();
    check("hold_valid1", mem_req_valid, 1'b0);
    mem_rsp_done = 1'b1;
    tick();
    check("hold_release", mem_req_valid, 1'b1);
    check("hold_pending", pending_cnt, 3);
    tick();
    mem_rsp_done = 1'b0;
    check("fire_done_pending", pending_cnt, 3);
    check("hold_ready", req_ready, 1'b1);
    check("hold_drained", exp_q.size(), 0);
    repeat (3) rsp_pulse();
    check("drain_pending", pending_cnt, 0);

    // LH misaligned on tid 2, then underflow
    send_req(0, 2'd0, 4'b0100, 4'b0001, {32'h0, 32'h1000, 64'h0}, '0, 32'd1, 44'h8, 5'd1, 1'b1);
    tick();
    check("lh_misalign", misalign_err, 1'b1);
    check("lh_ready", req_ready, 1'b1);
    check("lh_pending", pending_cnt, 0);
    check("pre_underflow", underflow_err, 1'b0);
    rsp_pulse();
    check("underflow", underflow_err, 1'b1);
    check("underflow_pending", pending_cnt, 0);

    // backpressure mid-ISSUE, then reset drops the request
    mem_req_ready = 1'b0;
    send_req(0, 2'd1, 4'b1111, 4'b0010, {32'h500C, 32'h5008, 32'h5004, 32'h5000}, '0,
             32'd0, 44'h9, 5'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_req_addr, 30'h1400);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_req_ready = 1'b1;
    check("rst2_ready", req_ready, 1'b1);
    check("rst2_valid", mem_req_valid, 1'b0);
    check("rst2_addr", mem_req_addr, 30'h0);
    check("rst2_pending", pending_cnt, 0);
    check("rst2_errs", {misalign_err, underflow_err}, 2'b00);
    repeat (10) tick();
    check("rst2_quiet", mem_req_valid, 1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    check("fence_q_final", fence_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
